// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch between the PC and ID, filling the IF/ID register
// with flush, stall, hold-buffer and timeout handling.
module if_fetch_stage #(
    parameter logic [31:0] NOP_INST       = 32'h00000000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_addr,
    input  logic        flush,
    input  logic        id_stall,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_err
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q, id_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic        slot_free, load_wait, load_hold, timeout;

    assign imem_req    = (state_q == REQ) && !flush;
    assign imem_addr   = inst_addr;
    assign pc_stall    = !(load_wait || load_hold || flush);
    assign id_valid    = id_valid_q;
    assign id_inst     = id_inst_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign fetch_err   = fetch_err_q;

    always_comb begin
        slot_free     = !id_stall || !id_valid_q;
        cnt_inc       = cnt_q + 16'd1;
        timeout       = (state_q == WAIT || state_q == DRAIN) && !imem_rvalid && cnt_inc == TO_LIMIT;
        load_wait     = !flush && state_q == WAIT && imem_rvalid && slot_free;
        load_hold     = !flush && state_q == HOLD && !id_stall;
        req_addr_d    = imem_req ? inst_addr : req_addr_q;
        cnt_d         = imem_req ? 16'd0
                      : ((state_q == WAIT || state_q == DRAIN) && !imem_rvalid) ? cnt_inc : cnt_q;
        hold_inst_d   = (state_q == WAIT && imem_rvalid) ? imem_rdata : hold_inst_q;
        hold_pc_d     = (state_q == WAIT && imem_rvalid) ? req_addr_q : hold_pc_q;
        fetch_err_d   = fetch_err_q || timeout;
        id_valid_d    = id_valid_q;
        id_inst_d     = id_inst_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        // flush wins over everything, including a stalled ID
        if (flush) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end else if (load_wait || load_hold) begin
            id_valid_d    = 1'b1;
            id_inst_d     = load_wait ? imem_rdata : hold_inst_q;
            id_pc_d       = load_wait ? req_addr_q : hold_pc_q;
            id_pc_plus4_d = (load_wait ? req_addr_q : hold_pc_q) + 32'd4;
        end else if (!id_stall) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end
        unique case (state_q)
            REQ:     state_d = flush ? REQ : WAIT;
            WAIT:    state_d = imem_rvalid ? ((flush || slot_free) ? REQ : HOLD)
                             : (timeout ? REQ : (flush ? DRAIN : WAIT));
            HOLD:    state_d = (flush || !id_stall) ? REQ : HOLD;
            DRAIN:   state_d = (imem_rvalid || timeout) ? REQ : DRAIN;
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= REQ;
            req_addr_q    <= '0;
            hold_inst_q   <= '0;
            hold_pc_q     <= '0;
            id_inst_q     <= NOP_INST;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            id_valid_q    <= 1'b0;
            fetch_err_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            hold_inst_q   <= hold_inst_d;
            hold_pc_q     <= hold_pc_d;
            id_inst_q     <= id_inst_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            fetch_err_q   <= fetch_err_d;
            cnt_q         <= cnt_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of if_fetch_stage with a scoreboard of expected IF/ID loads.
module tb_if_fetch_stage;
    logic        clk, rst_n, flush, id_stall, imem_rvalid;
    logic [31:0] inst_addr, imem_rdata;
    logic        pc_stall, imem_req, id_valid, fetch_err;
    logic [31:0] imem_addr, id_inst, id_pc, id_pc_plus4;

    typedef struct {logic [31:0] inst; logic [31:0] pc;} exp_t;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    if_fetch_stage #(.NOP_INST(32'h00000000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .inst_addr(inst_addr), .flush(flush), .id_stall(id_stall),
        .pc_stall(pc_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
        .id_inst(id_inst), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_load();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("load_valid", 32'(id_valid), 32'd1);
            chk("load_inst", id_inst, e.inst);
            chk("load_pc", id_pc, e.pc);
            chk("load_pc4", id_pc_plus4, e.pc + 32'd4);
        end
    endtask

    // one complete fetch starting in a REQ cycle, response after lat cycles
    task automatic fetch(input logic [31:0] addr, input int lat, input logic [31:0] data);
        inst_addr = addr;
        imem_rvalid = 1'b0;
        #1;
        chk("req", 32'(imem_req), 32'd1);
        chk("req_addr", imem_addr, addr);
        chk("stall_req", 32'(pc_stall), 32'd1);
        cyc();
        for (int i = 1; i < lat; i++) begin
            #1;
            chk("stall_wait", 32'(pc_stall), 32'd1);
            chk("noreq_wait", 32'(imem_req), 32'd0);
            cyc();
        end
        imem_rvalid = 1'b1;
        imem_rdata = data;
        sb.push_back('{data, addr});
        #1;
        chk("stall_load", 32'(pc_stall), 32'd0);
        cyc();
        imem_rvalid = 1'b0;
        check_load();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; id_stall = 1'b0; inst_addr = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_pc4", id_pc_plus4, 32'h0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        rst_n = 1'b1;
        fetch(32'h0, 1, 32'hA0000000);
        fetch(32'h4, 1, 32'hA0000004);
        fetch(32'h8, 1, 32'hA0000008);
        fetch(32'h40, 3, 32'hB0000040);
        fetch(32'h44, 1, 32'hC0000044);
        // ID stalls while a response arrives: word parks in the hold buffer
        id_stall = 1'b1;
        inst_addr = 32'h48;
        #1;
        chk("hold_req", 32'(imem_req), 32'd1);
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata = 32'h12345678;
        #1;
        chk("hold_stall_rv", 32'(pc_stall), 32'd1);
        cyc();
        imem_rvalid = 1'b0;
        #1;
        chk("hold_inst", id_inst, 32'hC0000044);
        chk("hold_pc", id_pc, 32'h44);
        chk("hold_valid", 32'(id_valid), 32'd1);
        chk("hold_stall", 32'(pc_stall), 32'd1);
        chk("hold_noreq", 32'(imem_req), 32'd0);
        cyc();
        chk("hold_inst2", id_inst, 32'hC0000044);
        id_stall = 1'b0;
        sb.push_back('{32'h12345678, 32'h48});
        #1;
        chk("hold_release_stall", 32'(pc_stall), 32'd0);
        cyc();
        check_load();
        // flush during WAIT, stale response must be dropped
        inst_addr = 32'h4C;
        #1;
        chk("fl_req", 32'(imem_req), 32'd1);
        cyc();
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(pc_stall), 32'd0);
        chk("fl_noreq", 32'(imem_req), 32'd0);
        cyc();
        flush = 1'b0;
        inst_addr = 32'h100;
        #1;
        chk("drain_valid", 32'(id_valid), 32'd0);
        chk("drain_noreq", 32'(imem_req), 32'd0);
        chk("drain_stall", 32'(pc_stall), 32'd1);
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        #1;
        chk("stale_stall", 32'(pc_stall), 32'd1);
        cyc();
        imem_rvalid = 1'b0;
        chk("stale_valid", 32'(id_valid), 32'd0);
        chk("stale_inst", id_inst, 32'h0);
        fetch(32'h100, 2, 32'hD0000100);
        // flush beats id_stall on a valid IF/ID
        id_stall = 1'b1;
        flush = 1'b1;
        #1;
        chk("fs_noreq", 32'(imem_req), 32'd0);
        chk("fs_stall", 32'(pc_stall), 32'd0);
        cyc();
        chk("fs_valid", 32'(id_valid), 32'd0);
        chk("fs_inst", id_inst, 32'h0);
        flush = 1'b0;
        id_stall = 1'b0;
        // timeout after 16 WAIT cycles without a response
        inst_addr = 32'h200;
        #1;
        chk("to_req", 32'(imem_req), 32'd1);
        cyc();
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("to_err_pre", 32'(fetch_err), 32'd0);
            chk("to_stall", 32'(pc_stall), 32'd1);
            cyc();
        end
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_reissue", 32'(imem_req), 32'd1);
        chk("to_addr", imem_addr, 32'h200);
        imem_rvalid = 1'b1;
        imem_rdata = 32'hBAD0BAD0;
        #1;
        chk("late_stall", 32'(pc_stall), 32'd1);
        cyc();
        chk("late_valid", 32'(id_valid), 32'd0);
        chk("late_inst", id_inst, 32'h0);
        imem_rdata = 32'h600D0200;
        sb.push_back('{32'h600D0200, 32'h200});
        #1;
        chk("refetch_stall", 32'(pc_stall), 32'd0);
        cyc();
        imem_rvalid = 1'b0;
        check_load();
        chk("err_sticky", 32'(fetch_err), 32'd1);
        // asynchronous reset in the middle of WAIT
        id_stall = 1'b1;
        inst_addr = 32'h300;
        #1;
        chk("ar_req", 32'(imem_req), 32'd1);
        cyc();
        #1;
        chk("ar_held", 32'(id_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(id_valid), 32'd0);
        chk("ar_inst", id_inst, 32'h0);
        chk("ar_pc", id_pc, 32'h0);
        chk("ar_pc4", id_pc_plus4, 32'h0);
        chk("ar_err", 32'(fetch_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        id_stall = 1'b0;
        fetch(32'h500, 2, 32'hE0000500);
        chk("post_err", 32'(fetch_err), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage between the PC register and the ID stage. Each cycle it takes the current instruction address from the PC and issues one request to instruction memory. It captures the returned word into the IF/ID pipeline register (instruction, PC, PC+4). It drives the PC stall input so the PC advances only after the word has been accepted. It also handles branch/jump redirects (flush), stalls from ID, and memory timeouts.

Parameters:
NOP_INST, 32'h00000000, instruction word driven on id_inst when id_valid=0
TIMEOUT_CYCLES, 255, wait cycles without imem_rvalid before abandoning a request (range 2..65535)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
inst_addr  in  32  current instruction address from the PC register
flush  in  1  redirect taken this cycle (branch or jump); the PC loads its target at the next edge
id_stall  in  1  ID cannot accept a new instruction; IF/ID outputs must hold
pc_stall  out  1  to the PC stall input; 1 = PC holds its value
imem_req  out  1  single-cycle fetch request strobe
imem_addr  out  32  fetch address, valid while imem_req=1
imem_rvalid  in  1  read data valid; at most one per request, at least 1 cycle after imem_req
imem_rdata  in  32  instruction word, valid with imem_rvalid
id_valid  out  1  IF/ID holds a real instruction
id_inst  out  32  IF/ID instruction word
id_pc  out  32  address of id_inst
id_pc_plus4  out  32  id_pc + 4
fetch_err  out  1  sticky flag: a memory timeout has occurred

Behaviour:
- FSM states: REQ, WAIT, HOLD, DRAIN. Reset state is REQ.
- Reset values: id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc_plus4=0, fetch_err=0, timeout counter=0, hold buffer empty.
- imem_req = (state==REQ) & ~flush. imem_addr = inst_addr, combinational.
- REQ: when imem_req=1, latch req_addr<=inst_addr, clear the counter, go to WAIT. When flush=1, stay in REQ and issue nothing.
- WAIT, imem_rvalid=1, and the IF/ID slot is free (id_stall=0 or id_valid=0):
  - load id_inst<=imem_rdata, id_pc<=req_addr, id_pc_plus4<=req_addr+4 (mod 2^32), id_valid<=1
  - go to REQ
- WAIT, imem_rvalid=1, slot not free: store rdata and req_addr in the hold buffer, go to HOLD.
- HOLD: when id_stall=0, move the buffer into IF/ID (id_valid<=1), go to REQ.
- IF/ID register when no instruction is loaded:
  - id_stall=1: all id_* outputs hold.
  - id_stall=0: id_valid<=0, id_inst<=NOP_INST (bubble).
- pc_stall:
  - 0 in the cycle an instruction is loaded into IF/ID (from WAIT or HOLD), so the PC advances at that same edge.
  - 1 in every other cycle of REQ, WAIT, HOLD and DRAIN.
  - Forced to 0 whenever flush=1, so the PC always takes the redirect.
  - Throughput: at most one instruction per 2 cycles (REQ + at least 1 WAIT).
- flush=1 (highest priority, any state):
  - id_valid<=0, id_inst<=NOP_INST, even when id_stall=1
  - hold buffer discarded
  - nothing from the current or stale request is ever loaded into IF/ID
  - next state: WAIT without rvalid → DRAIN; WAIT with rvalid same cycle → REQ (data dropped); HOLD → REQ; REQ → REQ; DRAIN → DRAIN.
- DRAIN: wait for the outstanding response and discard it; on imem_rvalid go to REQ.
- Timeout: the counter increments each WAIT or DRAIN cycle without rvalid. When it reaches TIMEOUT_CYCLES:
  - fetch_err<=1 (cleared only by rst_n)
  - go to REQ, which re-fetches the current inst_addr
  - a response arriving later while in REQ is ignored
- imem_rvalid in REQ or HOLD is a protocol violation and is ignored.
- rst_n assertion mid-transaction forces the reset state asynchronously. The first request issues in the first cycle after release, to the address then presented on inst_addr.

Test Plan:
- Reset, memory latency 1, PC starting at 0 → imem_addr 0, 4, 8 on alternating cycles; id_pc=0/4/8, id_pc_plus4=4/8/12, id_valid=1; pc_stall low exactly one cycle per fetch.
- Latency 3 at address 0x40 → pc_stall=1 for 3 cycles; id_inst=rdata, id_pc=0x40 on the 4th edge; PC then shows 0x44.
- id_stall=1 with id_valid=1 when rvalid arrives (rdata=0x12345678) → HOLD; id_* unchanged; pc_stall=1; drop id_stall → id_inst=0x12345678 next edge; pc_stall=0 that cycle.
- flush in WAIT (redirect to 0x100), stale rvalid 2 cycles later with 0xDEADBEEF → id_valid=0; 0xDEADBEEF never appears; next imem_addr=0x100.
- flush together with id_stall=1 and a valid IF/ID → id_valid=0 and id_inst=NOP_INST next edge; pc_stall=0 that cycle.
- TIMEOUT_CYCLES=16, no rvalid → fetch_err=1 after 16 WAIT cycles; request reissued to the same address; fetch_err stays 1 until rst_n; rst_n pulse mid-WAIT → all outputs return to reset values immediately.
